// File: rtl/k_nearest_select.sv
// Streaming K-nearest selector: keeps the K smallest labelled distances of an
// N-sample frame in a sorted list and emits them, nearest first, with valid_sort.
module k_nearest_select #(
  parameter int unsigned N      = 10,
  parameter int unsigned W      = 32,
  parameter int unsigned K      = 5,
  parameter int unsigned TYPE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_distance,
  input  logic [W-1:0]      distance,
  input  logic [TYPE_W-1:0] distance_type,
  output logic              ready,
  output logic [TYPE_W-1:0] k_nearest_neighbours_type     [0:K-1],
  output logic [W-1:0]      k_nearest_neighbours_distance [0:K-1],
  output logic              valid_sort
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic              list_vld  [0:K-1];
  logic [W-1:0]      list_dist [0:K-1];
  logic [TYPE_W-1:0] list_type [0:K-1];
  logic              nxt_vld   [0:K-1];
  logic [W-1:0]      nxt_dist  [0:K-1];
  logic [TYPE_W-1:0] nxt_type  [0:K-1];
  int unsigned       p;
  logic              accept;

  assign accept = valid_distance && ready;

  // Valid entries sit at the front, so counting "<=" hits gives the insert slot;
  // using <= places equal distances after earlier samples (stable order).
  always_comb begin
    p = 0;
    for (int unsigned i = 0; i < K; i++) begin
      if (list_vld[i] && (list_dist[i] <= distance)) p = p + 1;
    end
    if (p == 0) begin
      nxt_vld[0]  = 1'b1;
      nxt_dist[0] = distance;
      nxt_type[0] = distance_type;
    end else begin
      nxt_vld[0]  = list_vld[0];
      nxt_dist[0] = list_dist[0];
      nxt_type[0] = list_type[0];
    end
    for (int unsigned i = 1; i < K; i++) begin
      if (i < p) begin
        nxt_vld[i]  = list_vld[i];
        nxt_dist[i] = list_dist[i];
        nxt_type[i] = list_type[i];
      end else if (i == p) begin
        nxt_vld[i]  = 1'b1;
        nxt_dist[i] = distance;
        nxt_type[i] = distance_type;
      end else begin
        nxt_vld[i]  = list_vld[i-1];
        nxt_dist[i] = list_dist[i-1];
        nxt_type[i] = list_type[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      ready      <= 1'b1;
      valid_sort <= 1'b0;
      count      <= '0;
      for (int unsigned i = 0; i < K; i++) begin
        list_vld[i]                      <= 1'b0;
        list_dist[i]                     <= '0;
        list_type[i]                     <= '0;
        k_nearest_neighbours_type[i]     <= '0;
        k_nearest_neighbours_distance[i] <= '0;
      end
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            for (int unsigned i = 0; i < K; i++) begin
              list_vld[i]  <= nxt_vld[i];
              list_dist[i] <= nxt_dist[i];
              list_type[i] <= nxt_type[i];
            end
            count <= count + 1'b1;
            if (count == LAST) begin
              state      <= EMIT;
              ready      <= 1'b0;
              valid_sort <= 1'b1;
              for (int unsigned i = 0; i < K; i++) begin
                k_nearest_neighbours_type[i]     <= nxt_type[i];
                k_nearest_neighbours_distance[i] <= nxt_dist[i];
              end
            end
          end
        end
        EMIT: begin
          state      <= COLLECT;
          ready      <= 1'b1;
          valid_sort <= 1'b0;
          count      <= '0;
          for (int unsigned i = 0; i < K; i++) begin
            list_vld[i]  <= 1'b0;
            list_dist[i] <= '0;
            list_type[i] <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_k_nearest_select.sv
// Directed bench for k_nearest_select: hand-computed frames covering ordering,
// ties, all-ones distances, gaps/backpressure and mid-frame reset.
module tb_k_nearest_select;

  localparam int unsigned N      = 10;
  localparam int unsigned W      = 32;
  localparam int unsigned K      = 5;
  localparam int unsigned TYPE_W = 4;

  typedef logic [TYPE_W-1:0] types_t [0:K-1];
  typedef logic [W-1:0]      dists_t [0:K-1];
  typedef logic [W-1:0]      fdist_t [0:N-1];

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              valid_distance = 1'b0;
  logic [W-1:0]      distance = '0;
  logic [TYPE_W-1:0] distance_type = '0;
  logic              ready;
  logic [TYPE_W-1:0] k_nearest_neighbours_type     [0:K-1];
  logic [W-1:0]      k_nearest_neighbours_distance [0:K-1];
  logic              valid_sort;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  k_nearest_select #(.N(N), .W(W), .K(K), .TYPE_W(TYPE_W)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .valid_distance                (valid_distance),
    .distance                      (distance),
    .distance_type                 (distance_type),
    .ready                         (ready),
    .k_nearest_neighbours_type     (k_nearest_neighbours_type),
    .k_nearest_neighbours_distance (k_nearest_neighbours_distance),
    .valid_sort                    (valid_sort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid_sort) pulses++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_result(input string tag, input types_t et, input dists_t ed);
    for (int i = 0; i < K; i++) begin
      check($sformatf("%s type[%0d]", tag, i), 64'(k_nearest_neighbours_type[i]), 64'(et[i]));
      check($sformatf("%s dist[%0d]", tag, i), 64'(k_nearest_neighbours_distance[i]), 64'(ed[i]));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < K; i++) begin
      check($sformatf("%s type[%0d]", tag, i), 64'(k_nearest_neighbours_type[i]), 64'd0);
      check($sformatf("%s dist[%0d]", tag, i), 64'(k_nearest_neighbours_distance[i]), 64'd0);
    end
  endtask

  // Present one sample at a negedge and hold it until the next posedge takes it.
  task automatic send(input logic [W-1:0] d, input logic [TYPE_W-1:0] t, input bit gaps);
    int budget;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        valid_distance = 1'b0;
      end
    end
    @(negedge clk);
    valid_distance = 1'b1;
    distance       = d;
    distance_type  = t;
    budget = 0;
    while (!ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!ready) check("send timeout", 64'(ready), 64'd1);
  endtask

  task automatic send_frame(input fdist_t d, input bit gaps);
    for (int i = 0; i < N; i++) send(d[i], TYPE_W'(i), gaps);
  endtask

  // Cycle after the last accepted sample: pulse present, then gone.
  task automatic finish_frame(input string tag, input types_t et, input dists_t ed);
    @(negedge clk);
    valid_distance = 1'b0;
    check({tag, " valid_sort"}, 64'(valid_sort), 64'd1);
    check({tag, " ready in EMIT"}, 64'(ready), 64'd0);
    check_result(tag, et, ed);
    @(negedge clk);
    check({tag, " pulse width"}, 64'(valid_sort), 64'd0);
    check({tag, " ready after"}, 64'(ready), 64'd1);
  endtask

  fdist_t desc_d, tie_d, max_d;
  types_t desc_t, tie_t, max_t;
  dists_t desc_e, tie_e, max_e;
  int base;

  initial begin
    for (int i = 0; i < N; i++) begin
      desc_d[i] = W'(100 - 10 * i);
      tie_d[i]  = 32'd7;
    end
    max_d = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFF, 32'd3, 32'd1, 32'd2, 32'hFFFFFFFF};
    desc_t = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5};
    desc_e = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50};
    tie_t  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    tie_e  = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd7};
    max_t  = '{4'd7, 4'd8, 4'd6, 4'd0, 4'd1};
    max_e  = '{32'd1, 32'd2, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF};

    // Reset held two cycles
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("in reset valid_sort", 64'(valid_sort), 64'd0);
    check("in reset ready", 64'(ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post reset valid_sort", 64'(valid_sort), 64'd0);
    check("post reset ready", 64'(ready), 64'd1);
    check_zero("post reset");
    repeat (20) @(negedge clk);
    check("idle pulses", 64'(pulses), 64'd0);

    send_frame(desc_d, 1'b0);
    finish_frame("descending", desc_t, desc_e);

    // Ties; outputs must hold the previous result while collecting
    for (int i = 0; i < 5; i++) send(tie_d[i], TYPE_W'(i), 1'b0);
    check("hold type[0]", 64'(k_nearest_neighbours_type[0]), 64'd9);
    check("hold dist[4]", 64'(k_nearest_neighbours_distance[4]), 64'd50);
    for (int i = 5; i < N; i++) send(tie_d[i], TYPE_W'(i), 1'b0);
    finish_frame("ties", tie_t, tie_e);

    send_frame(max_d, 1'b0);
    finish_frame("max", max_t, max_e);

    // Gapped frame, then an 11th sample held through EMIT
    send_frame(desc_d, 1'b1);
    @(negedge clk);
    valid_distance = 1'b1;
    distance       = 32'd100;
    distance_type  = 4'd0;
    check("gaps valid_sort", 64'(valid_sort), 64'd1);
    check("gaps ready in EMIT", 64'(ready), 64'd0);
    check_result("gaps", desc_t, desc_e);
    @(negedge clk);
    check("held pulse width", 64'(valid_sort), 64'd0);
    check("held ready", 64'(ready), 64'd1);
    for (int i = 1; i < N; i++) send(desc_d[i], TYPE_W'(i), 1'b1);
    finish_frame("held frame2", desc_t, desc_e);
    check("pulses so far", 64'(pulses), 64'd5);

    // Abort a partial frame with reset
    base = pulses;
    for (int i = 0; i < 4; i++) send(32'd0, 4'hF, 1'b0);
    @(negedge clk);
    valid_distance = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_zero("mid reset");
    check("mid reset ready", 64'(ready), 64'd1);
    send_frame(desc_d, 1'b0);
    finish_frame("after abort", desc_t, desc_e);
    repeat (3) @(negedge clk);
    check("abort pulses", 64'(pulses - base), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
